// File: rtl/alarm_controller_if.sv
// Interface bundling the clock-time inputs, the user controls and the alarm status outputs.
// The master drives time and controls; the slave (the controller) drives status.
interface alarm_controller_if;
  logic [4:0] hr;
  logic [5:0] min;
  logic [5:0] sec;
  logic       alarm_on;
  logic       set_en;
  logic [4:0] set_hr;
  logic [5:0] set_min;
  logic       snooze;
  logic       stop;
  logic       ringing;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic [2:0] snooze_cnt;
  logic       set_err;

  modport master (
    output hr, min, sec, alarm_on, set_en, set_hr, set_min, snooze, stop,
    input  ringing, alarm_hr, alarm_min, snooze_cnt, set_err
  );

  modport slave (
    input  hr, min, sec, alarm_on, set_en, set_hr, set_min, snooze, stop,
    output ringing, alarm_hr, alarm_min, snooze_cnt, set_err
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm controller: compares running time with the programmed alarm and sequences
// DISARMED / ARMED / RINGING / SNOOZING with ring timeout and bounded snoozes.
module alarm_controller #(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic               clk,
  input  logic               reset,
  alarm_controller_if.slave  bus
);
  typedef enum logic [1:0] {S_DISARMED, S_ARMED, S_RINGING, S_SNOOZING} state_t;

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
  localparam logic [6:0] SNZ_ADD   = 7'(SNOOZE_MIN);
  localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);

  state_t     r_state, w_state_nxt;
  logic [4:0] r_alarm_hr, r_tgt_hr;
  logic [5:0] r_alarm_min, r_tgt_min;
  logic [7:0] r_ring_cnt;
  logic [2:0] r_snooze_cnt;
  logic       r_set_err, r_ringing;

  logic       w_match, w_set_win, w_set_rng_ok, w_set_ok, w_set_bad;
  logic       w_snz_allowed, w_ring_done;
  logic [6:0] w_m7, w_m7_sub;
  logic       w_wrap;
  logic [4:0] w_snz_hr;
  logic [5:0] w_snz_min;
  logic       w_tgt_from_alarm, w_tgt_from_snz, w_snz_clr, w_snz_inc, w_ring_clr, w_ring_inc;

  assign w_match       = (bus.sec == 6'd0) && (bus.hr == r_tgt_hr) && (bus.min == r_tgt_min);
  assign w_set_win     = (r_state == S_DISARMED) || (r_state == S_ARMED);
  assign w_set_rng_ok  = (bus.set_hr <= 5'd23) && (bus.set_min <= 6'd59);
  assign w_set_ok      = bus.set_en && w_set_win && w_set_rng_ok;
  assign w_set_bad     = bus.set_en && w_set_win && !w_set_rng_ok;
  assign w_snz_allowed = r_snooze_cnt < SNZ_MAX;
  assign w_ring_done   = r_ring_cnt == RING_LAST;

  // Snooze target: current hh:mm plus SNOOZE_MIN with hour and day wrap.
  assign w_m7      = {1'b0, bus.min} + SNZ_ADD;
  assign w_m7_sub  = w_m7 - 7'd60;
  assign w_wrap    = w_m7 >= 7'd60;
  assign w_snz_min = w_wrap ? w_m7_sub[5:0] : w_m7[5:0];
  assign w_snz_hr  = !w_wrap ? bus.hr : ((bus.hr == 5'd23) ? 5'd0 : bus.hr + 5'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_DISARMED;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.alarm_on) begin
      w_state_nxt = S_DISARMED;
    end else begin
      case (r_state)
        S_DISARMED: w_state_nxt = S_ARMED;
        S_ARMED:    if (w_match) w_state_nxt = S_RINGING;
        S_RINGING: begin
          if (bus.stop)                         w_state_nxt = S_ARMED;
          else if (bus.snooze && w_snz_allowed) w_state_nxt = S_SNOOZING;
          else if (w_ring_done)                 w_state_nxt = S_ARMED;
        end
        S_SNOOZING: begin
          if (bus.stop)     w_state_nxt = S_ARMED;
          else if (w_match) w_state_nxt = S_RINGING;
        end
        default: w_state_nxt = S_DISARMED;
      endcase
    end
  end

  always_comb begin
    w_tgt_from_alarm = 1'b0;
    w_tgt_from_snz   = 1'b0;
    w_snz_clr        = 1'b0;
    w_snz_inc        = 1'b0;
    w_ring_clr       = 1'b0;
    w_ring_inc       = 1'b0;
    if (!bus.alarm_on) begin
      w_snz_clr = 1'b1;
    end else begin
      case (r_state)
        S_DISARMED: w_tgt_from_alarm = 1'b1;
        S_ARMED:    w_ring_clr = w_match;
        S_RINGING: begin
          w_ring_inc = 1'b1;
          if (bus.stop || (!(bus.snooze && w_snz_allowed) && w_ring_done)) begin
            w_tgt_from_alarm = 1'b1;
            w_snz_clr        = 1'b1;
          end else if (bus.snooze && w_snz_allowed) begin
            w_tgt_from_snz = 1'b1;
            w_snz_inc      = 1'b1;
          end
        end
        S_SNOOZING: begin
          if (bus.stop) begin
            w_tgt_from_alarm = 1'b1;
            w_snz_clr        = 1'b1;
          end else begin
            w_ring_clr = w_match;
          end
        end
        default: w_snz_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alarm_hr   <= '0;
      r_alarm_min  <= '0;
      r_tgt_hr     <= '0;
      r_tgt_min    <= '0;
      r_ring_cnt   <= '0;
      r_snooze_cnt <= '0;
      r_set_err    <= 1'b0;
      r_ringing    <= 1'b0;
    end else begin
      r_set_err <= w_set_bad;
      r_ringing <= (w_state_nxt == S_RINGING);
      if (w_set_ok) begin
        r_alarm_hr  <= bus.set_hr;
        r_alarm_min <= bus.set_min;
      end
      // A set in ARMED retargets immediately; a match this edge still used the old target.
      if (w_set_ok && (r_state == S_ARMED)) begin
        r_tgt_hr  <= bus.set_hr;
        r_tgt_min <= bus.set_min;
      end else if (w_tgt_from_alarm) begin
        r_tgt_hr  <= r_alarm_hr;
        r_tgt_min <= r_alarm_min;
      end else if (w_tgt_from_snz) begin
        r_tgt_hr  <= w_snz_hr;
        r_tgt_min <= w_snz_min;
      end
      if (w_ring_clr)      r_ring_cnt <= '0;
      else if (w_ring_inc) r_ring_cnt <= r_ring_cnt + 8'd1;
      if (w_snz_clr)       r_snooze_cnt <= '0;
      else if (w_snz_inc)  r_snooze_cnt <= r_snooze_cnt + 3'd1;
    end
  end

  assign bus.ringing    = r_ringing;
  assign bus.alarm_hr   = r_alarm_hr;
  assign bus.alarm_min  = r_alarm_min;
  assign bus.snooze_cnt = r_snooze_cnt;
  assign bus.set_err    = r_set_err;
endmodule
